// File: rtl/shift_exec_pkg.sv
// Shared definitions for the execute-stage shift unit:
// op encodings, default widths and storage occupancy states.
package shift_exec_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int RD_W_DEF  = 4;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_ROR  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_e;

endpackage

// File: rtl/shift_exec_shift_core.sv
// Combinational log shifter: SLL, SRA, ROR and pass-through.
// Each level shifts by a power of two; the op picks the fill/wrap source.
module shift_core
    import shift_exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] result,
    output logic             z
);

    logic             fill;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] wrap;

    always_comb begin
        fill = (op == OP_SRA) && data[WIDTH-1];
        s    = data;
        wrap = '0;
        for (int k = 0; k < AMT_W; k++) begin
            // rotate refills from the value itself, SRA from the sign
            wrap = (op == OP_ROR) ? s : {WIDTH{fill}};
            if (amt[k]) begin
                if (op == OP_SLL) begin
                    s = s << (2 ** k);
                end else if (op != OP_PASS) begin
                    s = (s >> (2 ** k)) | (wrap << (WIDTH - 2 ** k));
                end
            end
        end
        result = s;
        z      = (s == '0);
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Execute-stage shift unit: computes on accept and holds results
// in a 2-entry buffer whose head register drives the EX/MEM outputs.
module shift_exec_stage
    import shift_exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RD_W  = RD_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [RD_W-1:0]          in_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [RD_W-1:0]          out_rd,
    output logic                     out_z
);

    localparam int EW = WIDTH + RD_W + 1;

    fill_e            state_q, state_d;
    logic [EW-1:0]    e0_q, e0_d;
    logic [EW-1:0]    e1_q, e1_d;
    logic [WIDTH-1:0] res;
    logic             res_z;
    logic [EW-1:0]    new_e;
    logic             push;
    logic             pop;

    shift_core #(.WIDTH(WIDTH)) u_core (
        .op     (in_op),
        .data   (in_data),
        .amt    (in_amt),
        .result (res),
        .z      (res_z)
    );

    assign new_e     = {res_z, in_rd, res};
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // e0 is the head; after a pop to empty it keeps the popped value
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        e0_d    = new_e;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        e0_d = new_e;
                    end else if (push) begin
                        e1_d    = new_e;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        e0_d    = e1_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign out_data = e0_q[WIDTH-1:0];
    assign out_rd   = e0_q[WIDTH+RD_W-1:WIDTH];
    assign out_z    = e0_q[EW-1];

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [15:0] in_data = 16'h0;
    logic [3:0]  in_amt = 4'h0;
    logic [3:0]  in_rd = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_rd;
    logic        out_z;

    int n_pass = 0;
    int n_total = 0;

    shift_exec_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_z     (out_z)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] ref_shift(logic [1:0] op, logic [15:0] d, int amt);
        logic [31:0] w;
        case (op)
            2'b00: return d << amt;
            2'b01: return 16'($signed(d) >>> amt);
            2'b10: begin
                w = {d, d} >> amt;
                return w[15:0];
            end
            default: return d;
        endcase
    endfunction

    typedef struct packed {
        logic        z;
        logic [3:0]  rd;
        logic [15:0] data;
    } ent_t;

    ent_t q[$];
    ent_t last;

    // Reference model: FIFO of at most two results
    always @(posedge clk or negedge rst_n) begin
        bit          push;
        bit          pop;
        logic [15:0] r;
        if (!rst_n) begin
            q.delete();
            last = '0;
        end else begin
            push = in_valid && (q.size() < 2) && !flush;
            pop  = (q.size() > 0) && out_ready && !flush;
            if (flush) begin
                if (q.size() > 0) last = q[0];
                q.delete();
            end else begin
                if (pop) last = q.pop_front();
                if (push) begin
                    r = ref_shift(in_op, in_data, int'(in_amt));
                    q.push_back('{z: (r == 16'h0), rd: in_rd, data: r});
                end
            end
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (rst_n) begin
            e = (q.size() > 0) ? q[0] : last;
            check("cyc_out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("cyc_in_ready", 32'(in_ready), 32'(q.size() < 2));
            check("cyc_out_data", 32'(out_data), 32'(e.data));
            check("cyc_out_rd", 32'(out_rd), 32'(e.rd));
            check("cyc_out_z", 32'(out_z), 32'(e.z));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(logic [1:0] op, logic [15:0] d, logic [3:0] a, logic [3:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        in_rd    = rd;
    endtask

    logic [1:0]  v_op  [10] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2};
    logic [15:0] v_dat [10] = '{16'h8001, 16'h7FFF, 16'h0001, 16'hA5A5, 16'hA5A5,
                                16'hA5A5, 16'hA5A5, 16'h0000, 16'h8001, 16'h00FF};
    logic [3:0]  v_amt [10] = '{4'd15, 4'd15, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd1, 4'd4};
    logic [15:0] v_exp [10] = '{16'hFFFF, 16'h0000, 16'h8000, 16'hA5A5, 16'hA5A5,
                                16'hA5A5, 16'hA5A5, 16'h0000, 16'h0002, 16'hF00F};

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_z", 32'(out_z), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        out_ready = 1'b1;
        drive(2'd0, 16'h00F1, 4'd4, 4'd3);
        step();
        in_valid = 1'b0;
        check("sll_valid", 32'(out_valid), 32'd1);
        check("sll_data", 32'(out_data), 32'h0F10);
        check("sll_rd", 32'(out_rd), 32'd3);
        check("sll_z", 32'(out_z), 32'd0);
        step();

        for (int i = 0; i < 10; i++) begin
            drive(v_op[i], v_dat[i], v_amt[i], 4'(i));
            step();
            check("vec_data", 32'(out_data), 32'(v_exp[i]));
            check("vec_z", 32'(out_z), 32'(v_exp[i] == 16'h0));
        end
        in_valid = 1'b0;
        step();

        out_ready = 1'b0;
        drive(2'd0, 16'h1234, 4'd0, 4'd1);
        step();
        drive(2'd2, 16'h00FF, 4'd4, 4'd2);
        step();
        in_valid = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", 32'(out_data), 32'h1234);
        step();
        check("stall_hold", 32'(out_data), 32'h1234);
        check("stall_rd", 32'(out_rd), 32'd1);
        out_ready = 1'b1;
        step();
        check("drain_b", 32'(out_data), 32'hF00F);
        check("drain_ready", 32'(in_ready), 32'd1);
        step();
        check("drain_empty", 32'(out_valid), 32'd0);
        check("idle_hold", 32'(out_data), 32'hF00F);

        for (int i = 0; i < 10; i++) begin
            drive(2'd0, 16'h0001, 4'(i), 4'(i));
            step();
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_data", 32'(out_data), 32'h1 << i);
        end
        in_valid = 1'b0;
        step();
        check("b2b_end", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        drive(2'd3, 16'h1111, 4'd0, 4'd5);
        step();
        drive(2'd3, 16'h2222, 4'd0, 4'd6);
        step();
        flush = 1'b1;
        drive(2'd3, 16'h3333, 4'd0, 4'd7);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_keep", 32'(out_data), 32'h1111);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            check("flush_gone", 32'(out_valid), 32'd0);
        end

        drive(2'd3, 16'h4444, 4'd0, 4'd8);
        step();
        flush = 1'b1;
        drive(2'd3, 16'h5555, 4'd0, 4'd9);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush1_valid", 32'(out_valid), 32'd0);
        check("flush1_keep", 32'(out_data), 32'h4444);
        step();
        check("flush1_gone", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        drive(2'd3, 16'h6666, 4'd0, 4'd1);
        step();
        drive(2'd3, 16'h7777, 4'd0, 4'd2);
        step();
        in_valid = 1'b0;
        check("prerst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
